// File: rtl/pea_pkg.sv
// Shared types and default widths for the polynomial evaluation accelerator.
package pea_pkg;

  localparam int unsigned PEA_RESULT_WIDTH = 32;
  localparam int unsigned PEA_STATUS_WIDTH = 8;
  localparam int unsigned PEA_COUNT_WIDTH  = 16;
  localparam int unsigned PEA_DESYNC_LIMIT = 8;

  localparam int unsigned STATUS_OK = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } drain_state_t;

endpackage

// File: rtl/pea_result_drain_if.sv
// FIFO-side and sink-side signals of the result drain; master is the drain itself.
interface pea_result_drain_if
  import pea_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = PEA_RESULT_WIDTH,
  parameter int unsigned STATUS_WIDTH = PEA_STATUS_WIDTH,
  parameter int unsigned COUNT_WIDTH  = PEA_COUNT_WIDTH
);

  logic                    result_empty;
  logic [RESULT_WIDTH-1:0] result_data;
  logic                    result_r_en;
  logic                    status_empty;
  logic [STATUS_WIDTH-1:0] status_data;
  logic                    status_r_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [RESULT_WIDTH-1:0] out_result;
  logic [STATUS_WIDTH-1:0] out_status;
  logic                    out_error;
  logic [COUNT_WIDTH-1:0]  record_count;
  logic [COUNT_WIDTH-1:0]  error_count;
  logic                    desync;

  modport master (
    input  result_empty, result_data, status_empty, status_data, out_ready,
    output result_r_en, status_r_en, out_valid, out_result, out_status,
           out_error, record_count, error_count, desync
  );

  modport slave (
    output result_empty, result_data, status_empty, status_data, out_ready,
    input  result_r_en, status_r_en, out_valid, out_result, out_status,
           out_error, record_count, error_count, desync
  );

endinterface

// File: rtl/pea_sat_counter.sv
// Up-counter that holds at its all-ones value instead of wrapping.
module pea_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != COUNT_MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pea_result_drain.sv
// Pops result and status FIFOs together, pairs them into one record per
// valid/ready transfer, and tracks record/error counts and FIFO desync.
module pea_result_drain
  import pea_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = PEA_RESULT_WIDTH,
  parameter int unsigned STATUS_WIDTH = PEA_STATUS_WIDTH,
  parameter int unsigned COUNT_WIDTH  = PEA_COUNT_WIDTH,
  parameter int unsigned DESYNC_LIMIT = PEA_DESYNC_LIMIT
) (
  input  logic               clock,
  input  logic               reset,
  pea_result_drain_if.master bus
);

  localparam int unsigned SIDE_WIDTH = $clog2(DESYNC_LIMIT + 1);

  drain_state_t state;
  drain_state_t state_next;

  logic                    both_ready;
  logic                    one_sided;
  logic                    pop;
  logic                    valid;
  logic                    accept;
  logic                    side_inc;
  logic [RESULT_WIDTH-1:0] result_q;
  logic [STATUS_WIDTH-1:0] status_q;
  logic                    error_q;
  logic                    desync_q;
  logic [COUNT_WIDTH-1:0]  record_cnt;
  logic [COUNT_WIDTH-1:0]  error_cnt;
  logic [SIDE_WIDTH-1:0]   side_cnt;

  assign both_ready = !bus.result_empty && !bus.status_empty;
  assign one_sided  = bus.result_empty != bus.status_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (both_ready) state_next = FETCH;
      FETCH:   state_next = PRESENT;
      PRESENT: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pop is gated by reset so no FIFO entry is lost while reset is held.
  always_comb begin
    pop   = 1'b0;
    valid = 1'b0;
    unique case (state)
      IDLE:    pop   = both_ready && !reset;
      PRESENT: valid = 1'b1;
      default: ;
    endcase
  end

  assign accept   = valid && bus.out_ready;
  assign side_inc = (state == IDLE) && one_sided;

  // FIFO read data arrives the cycle after the pop, i.e. during FETCH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      status_q <= '0;
      error_q  <= 1'b0;
    end else if (state == FETCH) begin
      result_q <= bus.result_data;
      status_q <= bus.status_data;
      error_q  <= bus.status_data != STATUS_WIDTH'(STATUS_OK);
    end
  end

  pea_sat_counter #(.WIDTH(COUNT_WIDTH)) u_record_count (
    .clock  (clock),
    .reset  (reset),
    .clear  (1'b0),
    .enable (accept),
    .count  (record_cnt)
  );

  pea_sat_counter #(.WIDTH(COUNT_WIDTH)) u_error_count (
    .clock  (clock),
    .reset  (reset),
    .clear  (1'b0),
    .enable (accept && error_q),
    .count  (error_cnt)
  );

  pea_sat_counter #(.WIDTH(SIDE_WIDTH)) u_side_count (
    .clock  (clock),
    .reset  (reset),
    .clear  (!one_sided),
    .enable (side_inc),
    .count  (side_cnt)
  );

  // Flag on the same edge the one-sided run reaches the limit; sticky.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      desync_q <= 1'b0;
    end else if (side_inc && (side_cnt >= SIDE_WIDTH'(DESYNC_LIMIT - 1))) begin
      desync_q <= 1'b1;
    end
  end

  assign bus.result_r_en  = pop;
  assign bus.status_r_en  = pop;
  assign bus.out_valid    = valid;
  assign bus.out_result   = result_q;
  assign bus.out_status   = status_q;
  assign bus.out_error    = error_q;
  assign bus.record_count = record_cnt;
  assign bus.error_count  = error_cnt;
  assign bus.desync       = desync_q;

endmodule
